// File: rtl/data_cache_if.sv
// ============================================================================
// Module      : data_cache_if
// Description : Core-side and memory-side bus bundle for data_cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_cache_if;
  // core side
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  // memory side
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_stall, proc_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_stall, proc_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/data_cache.sv
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-back / write-allocate data cache with
//               4-word lines. Optional hit/miss counters: DCACHE_HIT_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_cache #(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3
) (
  input  logic          clk,
  input  logic          proc_reset,
  data_cache_if.slave   bus
`ifdef DCACHE_HIT_COUNTER_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int c_tag_w = 28 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;
  logic [c_tag_w-1:0]     tag_q  [NUM_LINES];
  logic [127:0]           data_q [NUM_LINES];

  logic [INDEX_W-1:0]     w_index;
  logic [c_tag_w-1:0]     w_tag;
  logic [1:0]             w_offset;
  logic [6:0]             w_bitpos;
  logic                   w_req;
  logic                   w_hit;
  logic [127:0]           w_line;
  logic [c_tag_w-1:0]     w_vtag;
  logic [127:0]           w_wr_line;
  logic                   w_fill;
  logic                   w_wr_hit;
  logic                   w_stall;
  logic                   w_mem_read;
  logic                   w_mem_write;
  logic [27:0]            w_mem_addr;

  assign w_offset = bus.proc_addr[1:0];
  assign w_index  = bus.proc_addr[INDEX_W+1:2];
  assign w_tag    = bus.proc_addr[29:INDEX_W+2];
  assign w_bitpos = {w_offset, 5'b0};
  assign w_req    = bus.proc_read | bus.proc_write;
  assign w_line   = data_q[w_index];
  assign w_vtag   = tag_q[w_index];
  assign w_hit    = w_req && valid_q[w_index] && (w_vtag == w_tag);

  // Line image after merging the core's write word; written back on a write hit.
  always_comb begin
    w_wr_line = w_line;
    w_wr_line[w_bitpos +: 32] = bus.proc_wdata;
  end

  always_comb begin
    state_d     = state_q;
    w_stall     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = {w_tag, w_index};
    w_fill      = 1'b0;
    w_wr_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_wr_hit = bus.proc_write;
          end else begin
            w_stall = 1'b1;
            state_d = (valid_q[w_index] && dirty_q[w_index]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        w_stall     = 1'b1;
        w_mem_write = 1'b1;
        w_mem_addr  = {w_vtag, w_index};
        if (bus.mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        w_stall    = 1'b1;
        w_mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_fill  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_fill) begin
        valid_q[w_index] <= 1'b1;
        dirty_q[w_index] <= 1'b0;
      end else if (w_wr_hit) begin
        dirty_q[w_index] <= 1'b1;
      end
    end
  end

  // Data and tag arrays carry no reset; reset only blocks updates so an
  // abandoned transfer leaves the line untouched.
  always_ff @(posedge clk) begin
    if (!proc_reset) begin
      if (w_fill) begin
        data_q[w_index] <= bus.mem_rdata;
        tag_q[w_index]  <= w_tag;
      end else if (w_wr_hit) begin
        data_q[w_index] <= w_wr_line;
      end
    end
  end

  assign bus.proc_stall = w_stall;
  assign bus.proc_rdata = w_line[w_bitpos +: 32];
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_line;

`ifdef DCACHE_HIT_COUNTER_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        w_idle_hit;
  logic        w_idle_miss;

  assign w_idle_hit  = (state_q == IDLE) && w_hit;
  assign w_idle_miss = (state_q == IDLE) && w_req && !w_hit;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (w_idle_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (w_idle_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  a_mem_excl: assert property (@(posedge clk) !(bus.mem_read && bus.mem_write));

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
// ============================================================================
// Module      : tb_data_cache
// Description : Randomised self-checking bench for data_cache against a
//               program-view / backing-memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_cache;
  localparam int IW = 3;
  localparam int NL = 8;
  localparam int NW = 256;

  logic clk;
  logic rst;
  data_cache_if bus ();
`ifdef DCACHE_HIT_COUNTER_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache #(.NUM_LINES(NL), .INDEX_W(IW)) dut (
    .clk        (clk),
    .proc_reset (rst),
    .bus        (bus)
`ifdef DCACHE_HIT_COUNTER_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // mem_w: what external memory holds; view_w: what the program should read
  logic [31:0] mem_w  [NW];
  logic [31:0] view_w [NW];
  bit          m_valid [NL];
  bit          m_dirty [NL];
  int          m_tag   [NL];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] view_line(input int blk);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = view_w[blk*4 + w];
    return l;
  endfunction

  function automatic logic [127:0] mem_line(input int blk);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_w[blk*4 + w];
    return l;
  endfunction

  function automatic bit model_hit(input logic [29:0] a);
    int idx;
    idx = int'(a[IW+1:2]);
    return m_valid[idx] && (m_tag[idx] == int'(a >> (IW + 2)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < NW; i++) view_w[i] = mem_w[i];
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle_cycle(input bit stray_ready);
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.mem_ready  = stray_ready;
    bus.mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("idle_stall", 128'(bus.proc_stall), 128'(0));
    check("idle_memrw", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
  endtask

  task automatic access(input bit wr, input bit rd_too, input logic [29:0] a,
                        input logic [31:0] wd, input int lat_wb, input int lat_al);
    int idx, tg, blk, vblk, wa;
    bit hit, wb;
    logic [127:0] line;
    idx = int'(a[IW+1:2]);
    tg  = int'(a >> (IW + 2));
    blk = int'(a >> 2);
    wa  = int'(a[7:0]);
    hit = model_hit(a);
    wb  = !hit && m_valid[idx] && m_dirty[idx];
    bus.proc_read  = !wr || rd_too;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    bus.proc_wdata = wd;
    @(negedge clk);
    check("req_stall", 128'(bus.proc_stall), 128'(!hit));
    check("req_memrw", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    if (!hit) begin
      exp_misses++;
      @(posedge clk); #1;
      if (wb) begin
        vblk = (m_tag[idx] << IW) | idx;
        line = view_line(vblk);
        for (int k = 1; k <= lat_wb; k++) begin
          @(negedge clk);
          check("wb_memrw", 128'({bus.mem_read, bus.mem_write}), 128'(1));
          check("wb_stall", 128'(bus.proc_stall), 128'(1));
          check("wb_addr", 128'(bus.mem_addr), 128'(vblk));
          check("wb_data", bus.mem_wdata, line);
          if (k == lat_wb) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
          end
          @(posedge clk); #1;
          bus.mem_ready = 1'b0;
        end
        for (int w = 0; w < 4; w++) mem_w[vblk*4 + w] = view_w[vblk*4 + w];
      end
      for (int k = 1; k <= lat_al; k++) begin
        @(negedge clk);
        check("al_memrw", 128'({bus.mem_read, bus.mem_write}), 128'(2));
        check("al_stall", 128'(bus.proc_stall), 128'(1));
        check("al_addr", 128'(bus.mem_addr), 128'(blk));
        if (k == lat_al) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_line(blk);
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    @(negedge clk);
    check("hit_stall", 128'(bus.proc_stall), 128'(0));
    check("hit_memrw", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    if (!wr) check("hit_rdata", 128'(bus.proc_rdata), 128'(view_w[wa]));
    exp_hits++;
    @(posedge clk); #1;
    if (wr) begin
      view_w[wa]   = wd;
      m_dirty[idx] = 1'b1;
    end
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  // Issue a missing read and reset on its first transfer cycle, with
  // mem_ready high so an unguarded fill would corrupt the line.
  task automatic reset_mid(input logic [29:0] a);
    int idx;
    bit wb;
    idx = int'(a[IW+1:2]);
    wb  = m_valid[idx] && m_dirty[idx];
    bus.proc_read  = 1'b1;
    bus.proc_write = 1'b0;
    bus.proc_addr  = a;
    @(negedge clk);
    check("rm_stall", 128'(bus.proc_stall), 128'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("rm_memrw", 128'({bus.mem_read, bus.mem_write}), 128'(wb ? 1 : 2));
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    rst            = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.proc_read  = 1'b0;
    model_reset();
    @(negedge clk);
    check("rm_post_memrw", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    check("rm_post_stall", 128'(bus.proc_stall), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [29:0] a;
    int r;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    for (int i = 0; i < NW; i++) mem_w[i] = $urandom;
    mem_w[16] = 32'hDEAD_BEEF;
    mem_w[17] = 32'hDEAD_BEEF;
    model_reset();
    for (int i = 0; i < NL; i++) m_tag[i] = 0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycle(1'b0);
`ifdef DCACHE_HIT_COUNTER_EN
    check("cnt_reset", 128'({hit_count, miss_count}), 128'(0));
`endif

    access(1'b0, 1'b0, 30'h10, 32'h0, 1, 1);
    access(1'b1, 1'b0, 30'h10, 32'h1234_5678, 1, 1);
    access(1'b0, 1'b0, 30'h10, 32'h0, 1, 1);
    access(1'b0, 1'b0, 30'h30, 32'h0, 2, 3);
`ifdef DCACHE_HIT_COUNTER_EN
    check("hit_count", 128'(hit_count), 128'(4));
    check("miss_count", 128'(miss_count), 128'(2));
`endif
    access(1'b0, 1'b0, 30'h50, 32'h0, 1, 10);
    idle_cycle(1'b1);
    access(1'b1, 1'b1, 30'h51, 32'hCAFE_F00D, 1, 1);
    reset_mid(30'h70);
    access(1'b0, 1'b0, 30'h51, 32'h0, 1, 2);
    reset_mid(30'h88);
    access(1'b0, 1'b0, 30'h88, 32'h0, 1, 1);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      a = 30'($urandom_range(0, NW - 1));
      if (r < 3) begin
        idle_cycle(r == 0);
      end else if (r == 19 && !model_hit(a)) begin
        reset_mid(a);
      end else begin
        access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
               int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      end
    end

`ifdef DCACHE_HIT_COUNTER_EN
    check("final_hits", 128'(hit_count), 128'(exp_hits));
    check("final_misses", 128'(miss_count), 128'(exp_misses));
`endif
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
